// File: rtl/fighter_pkg.sv
// Shared types and constants for the stick-figure fighter motion controller:
// FSM states, key request encoding, action bit positions and default keymaps.
package fighter_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_WALK_L, S_WALK_R, S_KICK, S_PUNCH, S_JUMP, S_DODGE, S_KNOCK, S_FROZEN
    } state_t;

    typedef enum logic [2:0] {
        REQ_NONE, REQ_KICK, REQ_PUNCH, REQ_DODGE, REQ_JUMP, REQ_LEFT, REQ_RIGHT
    } req_t;

    // Bit positions of the one-hot action output
    localparam int A_STAND = 0, A_RIGHT = 1, A_LEFT  = 2, A_KICK = 3;
    localparam int A_FIGHT = 4, A_JUMP  = 5, A_DODGE = 6, A_BACK = 7;

    // Bit positions of the pressed-key vector
    localparam int K_LEFT = 0, K_RIGHT = 1, K_JUMP = 2, K_KICK = 3, K_PUNCH = 4, K_DODGE = 5;

    localparam logic [7:0] P1_KEY_LEFT  = 8'h04, P1_KEY_RIGHT = 8'h07, P1_KEY_JUMP  = 8'h1A;
    localparam logic [7:0] P1_KEY_KICK  = 8'h0D, P1_KEY_PUNCH = 8'h0E, P1_KEY_DODGE = 8'h16;
    localparam logic [7:0] P2_KEY_LEFT  = 8'h50, P2_KEY_RIGHT = 8'h4F, P2_KEY_JUMP  = 8'h52;
    localparam logic [7:0] P2_KEY_KICK  = 8'h59, P2_KEY_PUNCH = 8'h5A, P2_KEY_DODGE = 8'h62;

    function automatic logic [7:0] action_of(state_t s);
        logic [7:0] a;
        a = '0;
        case (s)
            S_WALK_L: a[A_LEFT]  = 1'b1;
            S_WALK_R: a[A_RIGHT] = 1'b1;
            S_KICK:   a[A_KICK]  = 1'b1;
            S_PUNCH:  a[A_FIGHT] = 1'b1;
            S_JUMP:   a[A_JUMP]  = 1'b1;
            S_DODGE:  a[A_DODGE] = 1'b1;
            S_KNOCK:  a[A_BACK]  = 1'b1;
            default:  a[A_STAND] = 1'b1;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/fighter_key_decode.sv
// Scans the packed keycode slots for this player's six keys and priority-encodes
// them into a single request; also exposes left/right for jump steering.
module fighter_key_decode
    import fighter_pkg::*;
#(
    parameter int         N_KEYSLOTS = 4,
    parameter logic [7:0] KEY_LEFT   = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT  = P1_KEY_RIGHT,
    parameter logic [7:0] KEY_JUMP   = P1_KEY_JUMP,
    parameter logic [7:0] KEY_KICK   = P1_KEY_KICK,
    parameter logic [7:0] KEY_PUNCH  = P1_KEY_PUNCH,
    parameter logic [7:0] KEY_DODGE  = P1_KEY_DODGE
) (
    input  logic [8*N_KEYSLOTS-1:0] keycodes,
    output req_t                    req,
    output logic [1:0]              steer
);

    logic [5:0] pressed;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pressed = '0;
        for (int i = 0; i < N_KEYSLOTS; i++) begin
            if (keycodes[8*i +: 8] != 8'h00) begin
                pressed[K_LEFT]  |= (keycodes[8*i +: 8] == KEY_LEFT);
                pressed[K_RIGHT] |= (keycodes[8*i +: 8] == KEY_RIGHT);
                pressed[K_JUMP]  |= (keycodes[8*i +: 8] == KEY_JUMP);
                pressed[K_KICK]  |= (keycodes[8*i +: 8] == KEY_KICK);
                pressed[K_PUNCH] |= (keycodes[8*i +: 8] == KEY_PUNCH);
                pressed[K_DODGE] |= (keycodes[8*i +: 8] == KEY_DODGE);
            end
        end
    end

    always_comb begin
        req = REQ_NONE;
        if      (pressed[K_KICK])  req = REQ_KICK;
        else if (pressed[K_PUNCH]) req = REQ_PUNCH;
        else if (pressed[K_DODGE]) req = REQ_DODGE;
        else if (pressed[K_JUMP])  req = REQ_JUMP;
        else if (pressed[K_LEFT])  req = REQ_LEFT;
        else if (pressed[K_RIGHT]) req = REQ_RIGHT;
    end

    assign steer = {pressed[K_LEFT], pressed[K_RIGHT]};

endmodule

// File: rtl/fighter_motion_ctrl.sv
// Per-player action FSM with X/Y integration, jump gravity, wall clamping and
// opponent push-back; all outputs are registered on frame_clk.
module fighter_motion_ctrl
    import fighter_pkg::*;
#(
    parameter int         N_KEYSLOTS    = 4,
    parameter int         START_X       = 100,
    parameter int         GROUND_Y      = 300,
    parameter int         X_MIN         = 10,
    parameter int         X_MAX         = 559,
    parameter int         WALK_STEP     = 5,
    parameter int         PUSH_STEP     = 1,
    parameter int         KNOCK_STEP    = 8,
    parameter int         NEAR_X        = 40,
    parameter int         NEAR_Y        = 50,
    parameter int         JUMP_V        = 12,
    parameter int         GRAVITY       = 1,
    parameter int         ATTACK_FRAMES = 12,
    parameter int         DODGE_FRAMES  = 16,
    parameter int         KNOCK_FRAMES  = 10,
    parameter logic [7:0] KEY_LEFT      = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT     = P1_KEY_RIGHT,
    parameter logic [7:0] KEY_JUMP      = P1_KEY_JUMP,
    parameter logic [7:0] KEY_KICK      = P1_KEY_KICK,
    parameter logic [7:0] KEY_PUNCH     = P1_KEY_PUNCH,
    parameter logic [7:0] KEY_DODGE     = P1_KEY_DODGE
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [8*N_KEYSLOTS-1:0] keycodes,
    input  logic [9:0]              opp_x,
    input  logic [9:0]              opp_y,
    input  logic                    hit_in,
    input  logic                    hit_dir,
    input  logic                    game_over,
    output logic [9:0]              pos_x,
    output logic [9:0]              pos_y,
    output logic [7:0]              action,
    output logic                    attack_strobe,
    output logic                    busy
);

    localparam logic signed [11:0] X_LO    = 12'(X_MIN);
    localparam logic signed [11:0] X_HI    = 12'(X_MAX);
    localparam logic signed [11:0] Y_FLOOR = 12'(GROUND_Y);
    localparam logic signed [10:0] V_JUMP  = 11'(JUMP_V);
    localparam logic signed [10:0] V_GRAV  = 11'(GRAVITY);
    localparam logic signed [10:0] D_WALK  = 11'(WALK_STEP);
    localparam logic signed [10:0] D_PUSH  = 11'(PUSH_STEP);
    localparam logic signed [10:0] D_KNOCK = 11'(KNOCK_STEP);
    localparam logic [9:0]         NEAR_DX = 10'(NEAR_X);
    localparam logic [9:0]         NEAR_DY = 10'(NEAR_Y);
    localparam logic [9:0]         FLOOR_U = 10'(GROUND_Y);
    localparam logic [9:0]         START_U = 10'(START_X);

    req_t               req;
    logic [1:0]         steer;
    state_t             state, state_n;
    logic [7:0]         timer, timer_n;
    logic signed [10:0] vy, vy_n, vy_eff, dx;
    logic signed [11:0] x_sum, y_sum;
    logic [9:0]         pos_x_n, pos_y_n, dist_x, dist_y;
    logic               knock_dir, knock_dir_n, jump_entry, landed, frozen, near;

    fighter_key_decode #(
        .N_KEYSLOTS(N_KEYSLOTS), .KEY_LEFT(KEY_LEFT), .KEY_RIGHT(KEY_RIGHT), .KEY_JUMP(KEY_JUMP),
        .KEY_KICK(KEY_KICK), .KEY_PUNCH(KEY_PUNCH), .KEY_DODGE(KEY_DODGE)
    ) u_key_decode (
        .keycodes (keycodes),
        .req      (req),
        .steer    (steer)
    );

    assign dist_x = (opp_x > pos_x) ? opp_x - pos_x : pos_x - opp_x;
    assign dist_y = (opp_y > pos_y) ? opp_y - pos_y : pos_y - opp_y;
    assign near   = (dist_x <= NEAR_DX) && (dist_y <= NEAR_DY);

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        knock_dir_n = knock_dir;
        jump_entry  = 1'b0;

        if (state == S_FROZEN || game_over) begin
            state_n = S_FROZEN;
            timer_n = '0;
        end else if (hit_in) begin
            state_n     = S_KNOCK;
            timer_n     = 8'(KNOCK_FRAMES);
            knock_dir_n = hit_dir;
        end else begin
            case (state)
                S_KICK, S_PUNCH, S_DODGE, S_KNOCK: begin
                    if (timer <= 8'd1) begin
                        state_n = S_IDLE;
                        timer_n = '0;
                    end else begin
                        timer_n = timer - 8'd1;
                    end
                end
                S_JUMP: ;  // exits on landing, resolved below
                default: begin
                    case (req)
                        REQ_KICK:  begin state_n = S_KICK;  timer_n = 8'(ATTACK_FRAMES); end
                        REQ_PUNCH: begin state_n = S_PUNCH; timer_n = 8'(ATTACK_FRAMES); end
                        REQ_DODGE: begin state_n = S_DODGE; timer_n = 8'(DODGE_FRAMES);  end
                        REQ_JUMP:  begin state_n = S_JUMP;  jump_entry = 1'b1;           end
                        REQ_LEFT:  state_n = S_WALK_L;
                        REQ_RIGHT: state_n = S_WALK_R;
                        default:   state_n = S_IDLE;
                    endcase
                end
            endcase
        end

        // Gravity runs whenever airborne, so a knockback mid-jump still falls.
        frozen  = (state_n == S_FROZEN);
        vy_eff  = jump_entry ? -V_JUMP : vy;
        y_sum   = $signed({2'b00, pos_y}) + $signed({vy_eff[10], vy_eff});
        landed  = 1'b0;
        pos_y_n = pos_y;
        vy_n    = vy;
        if (!frozen && (jump_entry || pos_y != FLOOR_U || vy != '0)) begin
            if (y_sum >= Y_FLOOR) begin
                pos_y_n = FLOOR_U;
                vy_n    = '0;
                landed  = 1'b1;
            end else begin
                pos_y_n = (y_sum < 0) ? 10'd0 : y_sum[9:0];
                vy_n    = vy_eff + V_GRAV;
            end
        end
        if (state_n == S_JUMP && landed)
            state_n = S_IDLE;

        // Motion belongs to the state being shown after this edge.
        case (state_n)
            S_WALK_L: dx = -D_WALK;
            S_WALK_R: dx = D_WALK;
            S_JUMP:   dx = steer[1] ? -D_WALK : (steer[0] ? D_WALK : 11'sd0);
            S_KNOCK:  dx = knock_dir_n ? D_KNOCK : -D_KNOCK;
            default:  dx = '0;
        endcase
        if (!frozen && near) begin
            if (opp_x > pos_x)      dx = -D_PUSH;
            else if (opp_x < pos_x) dx = D_PUSH;
        end

        x_sum   = $signed({2'b00, pos_x}) + $signed({dx[10], dx});
        pos_x_n = (x_sum < X_LO) ? X_LO[9:0] : (x_sum > X_HI) ? X_HI[9:0] : x_sum[9:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            vy            <= '0;
            knock_dir     <= 1'b0;
            pos_x         <= START_U;
            pos_y         <= FLOOR_U;
            action        <= 8'h01;
            attack_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            vy            <= vy_n;
            knock_dir     <= knock_dir_n;
            pos_x         <= pos_x_n;
            pos_y         <= pos_y_n;
            action        <= action_of(state_n);
            attack_strobe <= (state_n == S_KICK || state_n == S_PUNCH) && (state_n != state);
            busy          <= state_n inside {S_KICK, S_PUNCH, S_DODGE, S_JUMP, S_KNOCK};
        end
    end

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// Scoreboard bench for fighter_motion_ctrl: directed frames push hand-computed
// expectations, a negedge monitor pops and compares each registered output set.
module tb_fighter_motion_ctrl;

    localparam logic [7:0] KL = 8'h50, KR = 8'h4F, KJ = 8'h52, KK = 8'h59, KP = 8'h5A, KD = 8'h62;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [31:0] keycodes  = '0;
    logic [9:0]  opp_x     = 10'd0;
    logic [9:0]  opp_y     = 10'd300;
    logic        hit_in    = 1'b0;
    logic        hit_dir   = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  pos_x, pos_y;
    logic [7:0]  action;
    logic        attack_strobe, busy;

    typedef struct {
        string name;
        int    x;
        int    y;
        int    act;
        int    strobe;
        int    bsy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   jy[24]   = '{288, 277, 267, 258, 250, 243, 237, 232, 228, 225, 223, 222,
                       222, 223, 225, 228, 232, 237, 243, 250, 258, 267, 277, 288};

    fighter_motion_ctrl #(
        .N_KEYSLOTS(4), .START_X(539),
        .KEY_LEFT(KL), .KEY_RIGHT(KR), .KEY_JUMP(KJ),
        .KEY_KICK(KK), .KEY_PUNCH(KP), .KEY_DODGE(KD)
    ) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycodes      (keycodes),
        .opp_x         (opp_x),
        .opp_y         (opp_y),
        .hit_in        (hit_in),
        .hit_dir       (hit_dir),
        .game_over     (game_over),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .action        (action),
        .attack_strobe (attack_strobe),
        .busy          (busy)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge frame_clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, ".pos_x"},  int'(pos_x),         e.x);
            check({e.name, ".pos_y"},  int'(pos_y),         e.y);
            check({e.name, ".action"}, int'(action),        e.act);
            check({e.name, ".strobe"}, int'(attack_strobe), e.strobe);
            check({e.name, ".busy"},   int'(busy),          e.bsy);
        end
    end

    // Inputs are already set; record what the next edge must produce, then
    // advance to just after the following negedge.
    task automatic frame(input string name, input int x, input int y, input int act,
                         input int strobe, input int bsy);
        exp_t e;
        e.name = name; e.x = x; e.y = y; e.act = act; e.strobe = strobe; e.bsy = bsy;
        sb.push_back(e);
        @(negedge frame_clk);
        #1;
    endtask

    initial begin
        int x;

        Reset = 1'b1;
        repeat (2) frame("reset", 539, 300, 8'h01, 0, 0);
        Reset = 1'b0;
        repeat (10) frame("idle", 539, 300, 8'h01, 0, 0);

        keycodes = {24'h0, KR};
        x = 539;
        for (int i = 0; i < 20; i++) begin
            x = (x + 5 > 559) ? 559 : x + 5;
            frame("walk_r", x, 300, 8'h02, 0, 0);
        end
        keycodes = '0;
        frame("stop", 559, 300, 8'h01, 0, 0);

        keycodes = {KL, 8'h00, KJ, 8'h00};
        for (int i = 0; i < 24; i++)
            frame("jump_l", 559 - 5 * (i + 1), jy[i], 8'h20, 0, 1);
        frame("land", 439, 300, 8'h01, 0, 0);
        keycodes = '0;
        frame("after_land", 439, 300, 8'h01, 0, 0);

        keycodes = {16'h0, KK, 8'h00};
        frame("kick_first", 439, 300, 8'h08, 1, 1);
        for (int i = 1; i < 12; i++) begin
            keycodes = (i >= 3 && i <= 5) ? {24'h0, KP} : 32'h0;
            frame("kick_hold", 439, 300, 8'h08, 0, 1);
        end
        keycodes = '0;
        frame("kick_end", 439, 300, 8'h01, 0, 0);

        keycodes = {24'h0, KR};
        opp_x = 10'd469; opp_y = 10'd300; x = 439;
        for (int i = 0; i < 8; i++) begin
            x = x - 1;
            frame("push_back_l", x, 300, 8'h02, 0, 0);
        end
        opp_x = 10'd411;
        for (int i = 0; i < 3; i++) begin
            x = x + 1;
            frame("push_back_r", x, 300, 8'h02, 0, 0);
        end
        opp_x = 10'd434;                frame("same_x", 439, 300, 8'h02, 0, 0);
        opp_x = 10'd480;                frame("far_x41", 444, 300, 8'h02, 0, 0);
        opp_x = 10'd484;                frame("near_x40", 443, 300, 8'h02, 0, 0);
        opp_x = 10'd453; opp_y = 10'd351; frame("far_y51", 448, 300, 8'h02, 0, 0);
        opp_x = 10'd458; opp_y = 10'd350; frame("near_y50", 447, 300, 8'h02, 0, 0);
        opp_x = 10'd0;   opp_y = 10'd300; keycodes = '0;
        frame("release", 447, 300, 8'h01, 0, 0);

        keycodes = {8'h00, KP, 16'h0};
        frame("punch_first", 447, 300, 8'h10, 1, 1);
        keycodes = '0;
        repeat (2) frame("punch_hold", 447, 300, 8'h10, 0, 1);
        hit_in = 1'b1; hit_dir = 1'b0; x = 439;
        frame("knock_first", x, 300, 8'h80, 0, 1);
        hit_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            x = x - 8;
            frame("knock_hold", x, 300, 8'h80, 0, 1);
        end
        frame("knock_end", 367, 300, 8'h01, 0, 0);

        keycodes = {24'h0, KR}; hit_in = 1'b1; game_over = 1'b1;
        frame("frozen_wins", 367, 300, 8'h01, 0, 0);
        hit_in = 1'b0; game_over = 1'b0;
        repeat (5) frame("frozen_hold", 367, 300, 8'h01, 0, 0);
        Reset = 1'b1;
        frame("reset_frozen", 539, 300, 8'h01, 0, 0);
        Reset = 1'b0;
        frame("walk_after_reset", 544, 300, 8'h02, 0, 0);

        keycodes = {24'h0, KJ};
        frame("jump_up", 544, 288, 8'h20, 0, 1);
        frame("jump_up", 544, 277, 8'h20, 0, 1);
        frame("jump_up", 544, 267, 8'h20, 0, 1);
        keycodes = '0; Reset = 1'b1;
        frame("reset_mid_jump", 539, 300, 8'h01, 0, 0);
        Reset = 1'b0;
        repeat (3) frame("post_reset", 539, 300, 8'h01, 0, 0);

        keycodes = {24'h0, KK};
        frame("kick2_first", 539, 300, 8'h08, 1, 1);
        keycodes = '0;
        for (int i = 1; i < 11; i++) frame("kick2_hold", 539, 300, 8'h08, 0, 1);
        hit_in = 1'b1; hit_dir = 1'b1;
        frame("hit_last_frame", 547, 300, 8'h80, 0, 1);
        hit_in = 1'b0;
        frame("knock_r", 555, 300, 8'h80, 0, 1);
        frame("knock_r_clamp", 559, 300, 8'h80, 0, 1);

        repeat (2) @(negedge frame_clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
